dmem_arbiter: RTL and testbench

//  Shares the single data memory port between the CPU load/store path and an external master (loader/debug/DMA).
//  CPU has default priority so single-cycle execution is kept; the external master gets guaranteed service via a starvation counter.
//  The external master may lock the port for bursts; the lock is bounded so the CPU cannot starve either.

---
 rtl/dmem_arbiter_pkg.sv | 25 ++
 rtl/dmem_arb_sat_cnt.sv | 31 +++
 rtl/dmem_arbiter.sv | 151 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-memory arbiter: FSM states, port owners,
// access size codes shared with the decoder, and counter sizing.
package dmem_arbiter_pkg;

    typedef enum logic {
        IDLE     = 1'b0,
        EXT_LOCK = 1'b1
    } state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_EXT = 1'b1
    } owner_t;

    localparam logic [2:0] SIZE_B  = 3'b000;
    localparam logic [2:0] SIZE_H  = 3'b001;
    localparam logic [2:0] SIZE_W  = 3'b010;
    localparam logic [2:0] SIZE_BU = 3'b100;
    localparam logic [2:0] SIZE_HU = 3'b101;

    function automatic int unsigned cnt_w(input int unsigned max);
        return (max < 2) ? 1 : $clog2(max + 1);
    endfunction

endpackage

// File: rtl/dmem_arb_sat_cnt.sv
// Saturating up-counter with clear and a reached-maximum flag.
// Clear and increment together load 1 (first event of a new run).
module dmem_arb_sat_cnt
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned MAX = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    output logic at_max
);

    localparam int unsigned W = cnt_w(MAX);

    logic [W-1:0] cnt;

    assign at_max = (cnt == W'(MAX));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= inc ? W'(1) : '0;
        end else if (inc && !at_max) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter: CPU load/store path vs. external master,
// with starvation-forced ext grants and bounded ext lock bursts.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned MAX_BURST  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [2:0]        cpu_size_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_wdata_i,
    output logic              cpu_stall_o,
    output logic [DATA_W-1:0] cpu_rdata_o,
    input  logic              ext_req_i,
    input  logic              ext_lock_i,
    input  logic              ext_we_i,
    input  logic [2:0]        ext_size_i,
    input  logic [ADDR_W-1:0] ext_addr_i,
    input  logic [DATA_W-1:0] ext_wdata_i,
    output logic              ext_gnt_o,
    output logic [DATA_W-1:0] ext_rdata_o,
    output logic              ext_rvalid_o,
    output logic              mem_we_o,
    output logic [2:0]        mem_size_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    state_t state;
    state_t state_nx;
    owner_t owner;

    logic cpu_gnt;
    logic ext_gnt;
    logic starve_max;
    logic burst_max;
    logic burst_clr;
    logic burst_inc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        cpu_gnt   = 1'b0;
        ext_gnt   = 1'b0;
        burst_clr = 1'b0;
        burst_inc = 1'b0;
        case (state)
            IDLE: begin
                if (ext_req_i && (!cpu_req_i || starve_max)) begin
                    ext_gnt = 1'b1;
                end else if (cpu_req_i) begin
                    cpu_gnt = 1'b1;
                end
                if (ext_gnt && ext_lock_i) begin
                    state_nx  = EXT_LOCK;
                    burst_clr = 1'b1;
                    burst_inc = 1'b1;
                end
            end
            EXT_LOCK: begin
                // Burst bound reached: give the waiting CPU one slot.
                if (burst_max && cpu_req_i) begin
                    cpu_gnt   = 1'b1;
                    burst_clr = 1'b1;
                end else if (ext_req_i) begin
                    ext_gnt   = 1'b1;
                    burst_inc = cpu_req_i;
                end else if (cpu_req_i) begin
                    cpu_gnt = 1'b1;
                end
                if (!ext_lock_i || !ext_req_i) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    dmem_arb_sat_cnt #(
        .MAX(STARVE_MAX)
    ) u_starve (
        .clk   (clk),
        .reset (reset),
        .clr   (~ext_req_i | ext_gnt),
        .inc   (ext_req_i & ~ext_gnt),
        .at_max(starve_max)
    );

    dmem_arb_sat_cnt #(
        .MAX(MAX_BURST)
    ) u_burst (
        .clk   (clk),
        .reset (reset),
        .clr   (burst_clr),
        .inc   (burst_inc),
        .at_max(burst_max)
    );

    assign owner = ext_gnt ? OWN_EXT : OWN_CPU;

    always_comb begin
        mem_we_o    = 1'b0;
        mem_size_o  = cpu_size_i;
        mem_addr_o  = cpu_addr_i;
        mem_wdata_o = cpu_wdata_i;
        case (owner)
            OWN_EXT: begin
                mem_we_o    = ext_we_i;
                mem_size_o  = ext_size_i;
                mem_addr_o  = ext_addr_i;
                mem_wdata_o = ext_wdata_i;
            end
            default: begin
                mem_we_o = cpu_gnt & cpu_we_i;
            end
        endcase
    end

    assign cpu_stall_o = cpu_req_i & ~cpu_gnt;
    assign cpu_rdata_o = mem_rdata_i;
    assign ext_gnt_o   = ext_gnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ext_rvalid_o <= 1'b0;
            ext_rdata_o  <= '0;
        end else begin
            ext_rvalid_o <= ext_gnt & ~ext_we_i;
            if (ext_gnt && !ext_we_i) begin
                ext_rdata_o <= mem_rdata_i;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: grant table, multi-cycle
// sequences and a scoreboard for ext read returns.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, cpu_stall;
    logic [2:0]  cpu_size;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        ext_req, ext_lock, ext_we, ext_gnt, ext_rvalid;
    logic [2:0]  ext_size;
    logic [31:0] ext_addr, ext_wdata, ext_rdata;
    logic        mem_we;
    logic [2:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic [31:0] mem [0:255];
    logic [31:0] sb [$];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .cpu_req_i   (cpu_req),
        .cpu_we_i    (cpu_we),
        .cpu_size_i  (cpu_size),
        .cpu_addr_i  (cpu_addr),
        .cpu_wdata_i (cpu_wdata),
        .cpu_stall_o (cpu_stall),
        .cpu_rdata_o (cpu_rdata),
        .ext_req_i   (ext_req),
        .ext_lock_i  (ext_lock),
        .ext_we_i    (ext_we),
        .ext_size_i  (ext_size),
        .ext_addr_i  (ext_addr),
        .ext_wdata_i (ext_wdata),
        .ext_gnt_o   (ext_gnt),
        .ext_rdata_o (ext_rdata),
        .ext_rvalid_o(ext_rvalid),
        .mem_we_o    (mem_we),
        .mem_size_o  (mem_size),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_rdata_i (mem_rdata)
    );

    // Word-addressed data memory model, combinational read
    assign mem_rdata = mem[mem_addr[9:2]];

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Scoreboard: expected data queued on ext read grant, popped on rvalid
    always @(negedge clk) begin
        if (reset) begin
            sb.delete();
        end else begin
            if (ext_rvalid) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected_rvalid", 32'd1, 32'd0);
                end else begin
                    chk("sb_rdata", ext_rdata, sb.pop_front());
                end
            end
            if (ext_gnt && !ext_we) sb.push_back(mem[ext_addr[9:2]]);
        end
    end

    typedef struct {
        logic        cr, cw, er, el, ew;
        logic        stall, gnt, mwe;
        logic [31:0] maddr, mwdata;
    } vec_t;

    vec_t vt[9];

    task automatic idle_in();
        cpu_req = 0; cpu_we = 0; cpu_size = 3'b010;
        cpu_addr = 0; cpu_wdata = 0;
        ext_req = 0; ext_lock = 0; ext_we = 0; ext_size = 3'b010;
        ext_addr = 0; ext_wdata = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step();
        idle_in();
        reset = 1;
        @(negedge clk);
        chk("rst_stall", {31'd0, cpu_stall}, 32'd0);
        chk("rst_gnt", {31'd0, ext_gnt}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_rvalid", {31'd0, ext_rvalid}, 32'd0);
        chk("rst_rdata", ext_rdata, 32'd0);
        step();
        reset = 0;
    endtask

    // Hold current inputs; report the 1-based cycle of first ext grant
    task automatic wait_gnt(output int k);
        k = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (ext_gnt) begin
                k = c;
                break;
            end
            chk("wait_no_stall", {31'd0, cpu_stall}, 32'd0);
        end
    endtask

    initial begin
        int k;
        int i;
        int run;
        int maxrun;
        int ext_at_cpu;
        logic g;
        logic [31:0] saved;

        for (int a = 0; a < 256; a++) mem[a] = 32'h5A00_0000 | a;
        mem[8] = 32'h1234_5678;
        idle_in();
        reset = 1;
        #2;
        chk("async_rst_rvalid", {31'd0, ext_rvalid}, 32'd0);
        reset = 0;
        do_reset();

        vt[0] = '{0,0,0,0,0, 0,0,0, 32'h100, 32'hC0C0C0C0};
        vt[1] = '{1,0,0,0,0, 0,0,0, 32'h100, 32'hC0C0C0C0};
        vt[2] = '{1,1,0,0,0, 0,0,1, 32'h100, 32'hC0C0C0C0};
        vt[3] = '{0,0,1,0,0, 0,1,0, 32'h200, 32'hE0E0E0E0};
        vt[4] = '{0,0,1,0,1, 0,1,1, 32'h200, 32'hE0E0E0E0};
        vt[5] = '{1,1,1,0,1, 0,0,1, 32'h100, 32'hC0C0C0C0};
        vt[6] = '{1,0,1,1,1, 0,0,0, 32'h100, 32'hC0C0C0C0};
        vt[7] = '{0,1,0,0,1, 0,0,0, 32'h100, 32'hC0C0C0C0};
        vt[8] = '{0,0,1,1,0, 0,1,0, 32'h200, 32'hE0E0E0E0};

        foreach (vt[v]) begin
            do_reset();
            cpu_req = vt[v].cr; cpu_we = vt[v].cw;
            cpu_addr = 32'h100; cpu_wdata = 32'hC0C0C0C0;
            ext_req = vt[v].er; ext_lock = vt[v].el; ext_we = vt[v].ew;
            ext_addr = 32'h200; ext_wdata = 32'hE0E0E0E0;
            @(negedge clk);
            chk($sformatf("vec%0d_stall", v), {31'd0, cpu_stall}, {31'd0, vt[v].stall});
            chk($sformatf("vec%0d_gnt", v), {31'd0, ext_gnt}, {31'd0, vt[v].gnt});
            chk($sformatf("vec%0d_mem_we", v), {31'd0, mem_we}, {31'd0, vt[v].mwe});
            chk($sformatf("vec%0d_addr", v), mem_addr, vt[v].maddr);
            chk($sformatf("vec%0d_wdata", v), mem_wdata, vt[v].mwdata);
            step();
            idle_in();
            @(negedge clk);
        end

        // CPU store then load of the same word
        do_reset();
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h10; cpu_wdata = 32'hDEADBEEF;
        @(negedge clk);
        chk("t1_sw_stall", {31'd0, cpu_stall}, 32'd0);
        chk("t1_sw_mem_we", {31'd0, mem_we}, 32'd1);
        step();
        cpu_we = 0;
        @(negedge clk);
        chk("t1_lw_stall", {31'd0, cpu_stall}, 32'd0);
        chk("t1_lw_rdata", cpu_rdata, 32'hDEADBEEF);

        // Starvation-forced ext grant
        do_reset();
        cpu_req = 1; cpu_addr = 32'h0;
        ext_req = 1; ext_addr = 32'h20;
        wait_gnt(k);
        chk("t2_gnt_cycle", k, 5);
        chk("t2_stall_at_gnt", {31'd0, cpu_stall}, 32'd1);
        step();
        ext_req = 0;
        @(negedge clk);
        chk("t2_stall_after", {31'd0, cpu_stall}, 32'd0);
        chk("t2_rvalid", {31'd0, ext_rvalid}, 32'd1);
        chk("t2_rdata", ext_rdata, 32'h1234_5678);
        step();
        idle_in();

        // Locked 12-word write burst against continuous CPU traffic
        do_reset();
        cpu_req = 1; cpu_addr = 32'h0;
        ext_req = 1; ext_lock = 1; ext_we = 1;
        i = 0; ext_addr = 32'h40; ext_wdata = 32'hA000;
        run = 0; maxrun = 0; ext_at_cpu = -1;
        for (int c = 0; c < 60 && i < 12; c++) begin
            @(negedge clk);
            g = ext_gnt;
            if (cpu_stall) begin
                run++;
                if (run > maxrun) maxrun = run;
            end else begin
                run = 0;
                if (i > 0 && ext_at_cpu < 0) ext_at_cpu = i;
            end
            step();
            if (g) begin
                i++;
                ext_addr = 32'h40 + 4 * i;
                ext_wdata = 32'hA000 + i;
                ext_lock = (i < 11);
                if (i == 12) ext_req = 0;
            end
        end
        chk("t3_words_granted", i, 12);
        chk("t3_cpu_after_ext", ext_at_cpu, 8);
        chk("t3_max_stall_run", maxrun, 8);
        for (int w = 0; w < 12; w++) begin
            chk($sformatf("t3_word%0d", w), mem[16 + w], 32'hA000 + w);
        end
        idle_in();
        step();

        // Simultaneous single-cycle requests: CPU first, then ext
        do_reset();
        @(negedge clk);
        chk("t4_idle_stall", {31'd0, cpu_stall}, 32'd0);
        chk("t4_idle_gnt", {31'd0, ext_gnt}, 32'd0);
        chk("t4_idle_we", {31'd0, mem_we}, 32'd0);
        step();
        cpu_req = 1; cpu_addr = 32'h0;
        ext_req = 1; ext_addr = 32'h10;
        @(negedge clk);
        chk("t4_cpu_stall", {31'd0, cpu_stall}, 32'd0);
        chk("t4_ext_wait", {31'd0, ext_gnt}, 32'd0);
        step();
        cpu_req = 0;
        @(negedge clk);
        chk("t4_ext_gnt", {31'd0, ext_gnt}, 32'd1);
        step();
        ext_req = 0;
        @(negedge clk);
        chk("t4_rvalid", {31'd0, ext_rvalid}, 32'd1);
        chk("t4_rdata", ext_rdata, 32'hDEADBEEF);
        step();

        // Reset right after a locked ext read grant
        do_reset();
        saved = mem[8];
        ext_req = 1; ext_lock = 1; ext_addr = 32'h20;
        @(negedge clk);
        chk("t5_gnt", {31'd0, ext_gnt}, 32'd1);
        step();
        reset = 1;
        cpu_req = 1; cpu_addr = 32'h0;
        @(negedge clk);
        chk("t5_rvalid", {31'd0, ext_rvalid}, 32'd0);
        chk("t5_rdata", ext_rdata, 32'd0);
        chk("t5_idle_gnt", {31'd0, ext_gnt}, 32'd0);
        chk("t5_idle_stall", {31'd0, cpu_stall}, 32'd0);
        chk("t5_mem_we", {31'd0, mem_we}, 32'd0);
        step();
        reset = 0;
        wait_gnt(k);
        chk("t5_starve_from_zero", k, 5);
        step();
        idle_in();
        @(negedge clk);
        chk("t5_mem_kept", mem[8], saved);
        step();

        // Lock released mid-burst while CPU waits
        do_reset();
        ext_req = 1; ext_lock = 1; ext_we = 1;
        ext_addr = 32'h80; ext_wdata = 32'h66;
        @(negedge clk);
        chk("t6_gnt0", {31'd0, ext_gnt}, 32'd1);
        step();
        cpu_req = 1; cpu_addr = 32'h0;
        ext_addr = 32'h84; ext_wdata = 32'h67;
        @(negedge clk);
        chk("t6_gnt1", {31'd0, ext_gnt}, 32'd1);
        chk("t6_stall1", {31'd0, cpu_stall}, 32'd1);
        step();
        ext_lock = 0; ext_addr = 32'h88; ext_wdata = 32'h68;
        @(negedge clk);
        chk("t6_gnt2", {31'd0, ext_gnt}, 32'd1);
        chk("t6_stall2", {31'd0, cpu_stall}, 32'd1);
        step();
        ext_req = 0; ext_we = 0;
        @(negedge clk);
        chk("t6_cpu_gnt", {31'd0, cpu_stall}, 32'd0);
        chk("t6_no_ext", {31'd0, ext_gnt}, 32'd0);
        chk("t6_last_word", mem[34], 32'h68);
        step();
        idle_in();
        step();
        @(negedge clk);

        chk("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
